// File: rtl/tlc_pkg.sv
// Shared types and light encodings for the multiphase traffic-light controller.
// The state encoding leaves 3'd7 unused; the controller maps it back to IDLE.
package tlc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GREEN     = 3'd1,
        YELLOW    = 3'd2,
        ALL_RED   = 3'd3,
        PED_WALK  = 3'd4,
        PED_CLEAR = 3'd5,
        EMER_HOLD = 3'd6
    } state_t;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin search over the pending-car mask.
// The search starts just after i_cur, wraps, and ends at i_cur itself.
module tlc_rr_pick #(
    parameter int N_PHASES = 4
) (
    input  logic [N_PHASES-1:0]         i_pend,
    input  logic [$clog2(N_PHASES)-1:0] i_cur,
    output logic                        o_valid,
    output logic [$clog2(N_PHASES)-1:0] o_idx
);

    localparam int PW = $clog2(N_PHASES);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        logic [PW-1:0] w_cand;
        o_valid = 1'b0;
        o_idx   = i_cur;
        w_cand  = '0;
        // Walk from the farthest candidate to the nearest so the nearest hit wins.
        for (int k = N_PHASES; k >= 1; k--) begin
            w_cand = PW'((int'(i_cur) + k) % N_PHASES);
            if (i_pend[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/tlc_multiphase.sv
// N-phase intersection controller with latched car/pedestrian requests and
// emergency preemption that always clears through yellow and all-red.
module tlc_multiphase
    import tlc_pkg::*;
#(
    parameter int N_PHASES      = 4,
    parameter int TW            = 8,
    parameter int YELLOW_CYC    = 3,
    parameter int ALLRED_CYC    = 2,
    parameter int PED_CLEAR_CYC = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [TW-1:0]               green_time,
    input  logic [TW-1:0]               walk_time,
    input  logic [N_PHASES-1:0]         car_req,
    input  logic                        ped_req,
    input  logic                        emergency,
    output logic [3*N_PHASES-1:0]       lights,
    output logic                        ped_walk,
    output logic                        ped_flash,
    output logic                        emer_active,
    output logic [$clog2(N_PHASES)-1:0] cur_phase
);

    localparam int            PW        = $clog2(N_PHASES);
    localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_CYC - 1);
    localparam logic [TW-1:0] PC_LAST   = TW'(PED_CLEAR_CYC - 1);
    localparam logic [TW-1:0] TIMER_MAX = '1;

    state_t                  r_state;
    logic [TW-1:0]           r_timer;
    logic [TW-1:0]           r_dwell;
    logic [N_PHASES-1:0]     r_car_pend;
    logic                    r_ped_pend;
    logic [PW-1:0]           r_cur_phase;
    logic [3*N_PHASES-1:0]   r_lights;
    logic                    r_ped_walk;
    logic                    r_ped_flash;
    logic                    r_emer_active;

    state_t                  w_next_state;
    state_t                  w_dec_state;
    logic [PW-1:0]           w_next_phase;
    logic [PW-1:0]           w_dec_phase;
    logic [PW-1:0]           w_pick_idx;
    logic                    w_pick_valid;
    logic                    w_green_entry;
    logic                    w_walk_entry;
    logic [TW-1:0]           w_green_dwell;
    logic [TW-1:0]           w_walk_dwell;
    logic [N_PHASES-1:0]     w_grant_mask;
    logic [3*N_PHASES-1:0]   w_next_lights;

    tlc_rr_pick #(
        .N_PHASES (N_PHASES)
    ) u_rr_pick (
        .i_pend  (r_car_pend),
        .i_cur   (r_cur_phase),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_green_dwell = (green_time == '0) ? TW'(1) : green_time;
    assign w_walk_dwell  = (walk_time  == '0) ? TW'(1) : walk_time;

    // Shared decision point: emergency, then pedestrians, then round-robin cars.
    always_comb begin
        w_dec_state = IDLE;
        w_dec_phase = r_cur_phase;
        if (emergency) begin
            w_dec_state = EMER_HOLD;
        end else if (r_ped_pend) begin
            w_dec_state = PED_WALK;
        end else if (w_pick_valid) begin
            w_dec_state = GREEN;
            w_dec_phase = w_pick_idx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_phase = r_cur_phase;
        case (r_state)
            IDLE: begin
                w_next_state = w_dec_state;
                w_next_phase = w_dec_phase;
            end
            GREEN: begin
                if (emergency || r_timer == r_dwell - TW'(1)) w_next_state = YELLOW;
            end
            YELLOW: begin
                if (r_timer == YEL_LAST) w_next_state = ALL_RED;
            end
            ALL_RED: begin
                if (r_timer == AR_LAST) begin
                    w_next_state = w_dec_state;
                    w_next_phase = w_dec_phase;
                end
            end
            PED_WALK: begin
                if (emergency || r_timer == r_dwell - TW'(1)) w_next_state = PED_CLEAR;
            end
            PED_CLEAR: begin
                if (r_timer == PC_LAST) w_next_state = ALL_RED;
            end
            EMER_HOLD: begin
                if (!emergency) w_next_state = ALL_RED;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_green_entry = (w_next_state == GREEN)    && (r_state != GREEN);
    assign w_walk_entry  = (w_next_state == PED_WALK) && (r_state != PED_WALK);

    // Lights are decoded from the next state so they switch with the state register.
    always_comb begin
        w_grant_mask  = '0;
        w_next_lights = '0;
        if (w_green_entry) w_grant_mask[w_next_phase] = 1'b1;
        for (int i = 0; i < N_PHASES; i++) begin
            w_next_lights[3*i +: 3] = LT_RED;
            if (PW'(i) == w_next_phase) begin
                if (w_next_state == GREEN)  w_next_lights[3*i +: 3] = LT_GRN;
                if (w_next_state == YELLOW) w_next_lights[3*i +: 3] = LT_YEL;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_dwell       <= '0;
            r_car_pend    <= '0;
            r_ped_pend    <= 1'b0;
            r_cur_phase   <= PW'(N_PHASES - 1);
            r_lights      <= {N_PHASES{LT_RED}};
            r_ped_walk    <= 1'b0;
            r_ped_flash   <= 1'b0;
            r_emer_active <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_timer <= '0;
            end else if (r_timer != TIMER_MAX) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_green_entry) begin
                r_dwell <= w_green_dwell;
            end else if (w_walk_entry) begin
                r_dwell <= w_walk_dwell;
            end
            // A request arriving on the grant edge is absorbed by that grant.
            r_car_pend    <= (r_car_pend | car_req) & ~w_grant_mask;
            r_ped_pend    <= (r_ped_pend | ped_req) & ~w_walk_entry;
            r_cur_phase   <= w_next_phase;
            r_lights      <= w_next_lights;
            r_ped_walk    <= (w_next_state == PED_WALK);
            r_ped_flash   <= (w_next_state == PED_CLEAR);
            r_emer_active <= (w_next_state == EMER_HOLD);
        end
    end

    assign lights      = r_lights;
    assign ped_walk    = r_ped_walk;
    assign ped_flash   = r_ped_flash;
    assign emer_active = r_emer_active;
    assign cur_phase   = r_cur_phase;

endmodule

// File: tb/tb_tlc_multiphase.sv
// Scoreboard bench: stimulus queues expected output segments (outputs + length),
// a negedge monitor closes each segment when the outputs change and compares.
module tb_tlc_multiphase;
    import tlc_pkg::*;

    localparam logic [11:0] ALL_RED_LT = 12'h924;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  green_time = 8'd5;
    logic [7:0]  walk_time  = 8'd6;
    logic [3:0]  car_req    = 4'b0000;
    logic        ped_req    = 1'b0;
    logic        emergency  = 1'b0;
    logic [11:0] lights;
    logic        ped_walk;
    logic        ped_flash;
    logic        emer_active;
    logic [1:0]  cur_phase;

    always #5 clk = ~clk;

    tlc_multiphase #(
        .N_PHASES      (4),
        .TW            (8),
        .YELLOW_CYC    (3),
        .ALLRED_CYC    (2),
        .PED_CLEAR_CYC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .green_time  (green_time),
        .walk_time   (walk_time),
        .car_req     (car_req),
        .ped_req     (ped_req),
        .emergency   (emergency),
        .lights      (lights),
        .ped_walk    (ped_walk),
        .ped_flash   (ped_flash),
        .emer_active (emer_active),
        .cur_phase   (cur_phase)
    );

    typedef struct packed {
        logic [11:0] lt;
        logic        walk;
        logic        flash;
        logic        emer;
        logic [1:0]  ph;
    } sig_t;

    typedef struct {
        sig_t s;
        int   dur;
    } seg_t;

    seg_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   seg_no   = 0;
    bit   mon_en   = 1'b0;
    bit   mon_started = 1'b0;
    sig_t mon_cur;
    int   mon_run  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic sig_t mk(input int p, input logic [2:0] v, input logic w,
                                input logic f, input logic e, input logic [1:0] ph);
        sig_t s;
        s.lt = ALL_RED_LT;
        if (p >= 0) s.lt[3*p +: 3] = v;
        s.walk  = w;
        s.flash = f;
        s.emer  = e;
        s.ph    = ph;
        return s;
    endfunction

    function automatic sig_t g_sig(input int p);
        return mk(p, 3'b001, 1'b0, 1'b0, 1'b0, 2'(p));
    endfunction

    function automatic sig_t y_sig(input int p);
        return mk(p, 3'b010, 1'b0, 1'b0, 1'b0, 2'(p));
    endfunction

    function automatic sig_t ar_sig(input int ph);
        return mk(-1, 3'b100, 1'b0, 1'b0, 1'b0, 2'(ph));
    endfunction

    function automatic int nonred(input logic [11:0] lt);
        int n = 0;
        for (int i = 0; i < 4; i++) if (lt[3*i +: 3] != 3'b100) n++;
        return n;
    endfunction

    // dur == 0 means the segment length is open-ended (idle tail).
    task automatic expect_seg(input sig_t s, input int d);
        seg_t e;
        e.s   = s;
        e.dur = d;
        exp_q.push_back(e);
    endtask

    task automatic close_seg();
        seg_t e;
        seg_no++;
        if (exp_q.size() == 0) begin
            check($sformatf("segment%0d_expected", seg_no), 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("segment%0d_outputs", seg_no), 32'(mon_cur), 32'(e.s));
        if (e.dur != 0) check($sformatf("segment%0d_cycles", seg_no), 32'(mon_run), 32'(e.dur));
    endtask

    always @(negedge clk) begin
        sig_t s;
        if (mon_en) begin
            s = {lights, ped_walk, ped_flash, emer_active, cur_phase};
            check("walk_flash_exclusive", 32'(ped_walk & ped_flash), 32'd0);
            check("at_most_one_non_red", 32'(nonred(lights) <= 1), 32'd1);
            if (!mon_started) begin
                mon_cur     = s;
                mon_run     = 1;
                mon_started = 1'b1;
            end else if (s == mon_cur) begin
                mon_run++;
            end else begin
                close_seg();
                mon_cur = s;
                mon_run = 1;
            end
        end
    end

    task automatic hold_car(input logic [3:0] m, input int n);
        @(posedge clk);
        #1 car_req = m;
        repeat (n) @(posedge clk);
        #1 car_req = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(2);
        #1;
        check("reset_lights", 32'(lights), 32'(ALL_RED_LT));
        check("reset_ped_walk", 32'(ped_walk), 32'd0);
        check("reset_ped_flash", 32'(ped_flash), 32'd0);
        check("reset_emer_active", 32'(emer_active), 32'd0);
        check("reset_cur_phase", 32'(cur_phase), 32'd3);
        check("reset_car_pend", 32'(dut.r_car_pend), 32'd0);
        check("reset_ped_pend", 32'(dut.r_ped_pend), 32'd0);
        rst = 1'b0;
        expect_seg(ar_sig(3), 0);
        mon_en = 1'b1;
        idle(3);

        // Single request on phase 2
        expect_seg(g_sig(2), 5);
        expect_seg(y_sig(2), 3);
        expect_seg(ar_sig(2), 0);
        hold_car(4'b0100, 1);
        idle(14);
        #1 check("single_cur_phase", 32'(cur_phase), 32'd2);

        // Serve phase 1 so round robin starts from cur_phase = 1
        expect_seg(g_sig(1), 5);
        expect_seg(y_sig(1), 3);
        expect_seg(ar_sig(1), 0);
        hold_car(4'b0010, 1);
        idle(14);

        // Round robin over 1011 from cur_phase 1: 3, 0, 1
        expect_seg(g_sig(3), 5);
        expect_seg(y_sig(3), 3);
        expect_seg(ar_sig(3), 2);
        expect_seg(g_sig(0), 5);
        expect_seg(y_sig(0), 3);
        expect_seg(ar_sig(0), 2);
        expect_seg(g_sig(1), 5);
        expect_seg(y_sig(1), 3);
        expect_seg(ar_sig(1), 0);
        hold_car(4'b1011, 2);
        idle(34);

        // Pedestrian during phase-0 green, car on phase 2 served afterwards
        expect_seg(g_sig(0), 5);
        expect_seg(y_sig(0), 3);
        expect_seg(ar_sig(0), 2);
        expect_seg(mk(-1, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0), 6);
        expect_seg(mk(-1, 3'b100, 1'b0, 1'b1, 1'b0, 2'd0), 4);
        expect_seg(ar_sig(0), 2);
        expect_seg(g_sig(2), 5);
        expect_seg(y_sig(2), 3);
        expect_seg(ar_sig(2), 0);
        hold_car(4'b0001, 1);
        @(posedge clk);
        #1 car_req = 4'b0100;
        ped_req = 1'b1;
        @(posedge clk);
        #1 car_req = 4'b0000;
        ped_req = 1'b0;
        idle(36);

        // Emergency in the first green cycle of phase 1, phase 3 latched in hold
        expect_seg(g_sig(1), 1);
        expect_seg(y_sig(1), 3);
        expect_seg(ar_sig(1), 2);
        expect_seg(mk(-1, 3'b100, 1'b0, 1'b0, 1'b1, 2'd1), 5);
        expect_seg(ar_sig(1), 2);
        expect_seg(g_sig(3), 5);
        expect_seg(y_sig(3), 3);
        expect_seg(ar_sig(3), 0);
        hold_car(4'b0010, 1);
        @(posedge clk);
        #1 emergency = 1'b1;
        idle(6);
        #1 car_req = 4'b1000;
        @(posedge clk);
        #1 car_req = 4'b0000;
        idle(3);
        #1 emergency = 1'b0;
        idle(16);

        // Zero green time, then reset during yellow drops pending requests
        green_time = 8'd0;
        expect_seg(g_sig(0), 1);
        expect_seg(y_sig(0), 1);
        expect_seg(ar_sig(3), 0);
        hold_car(4'b0001, 1);
        @(posedge clk);
        #1 car_req = 4'b0100;
        ped_req = 1'b1;
        @(posedge clk);
        #1 car_req = 4'b0000;
        ped_req = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_lights", 32'(lights), 32'(ALL_RED_LT));
        check("midreset_cur_phase", 32'(cur_phase), 32'd3);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_car_pend", 32'(dut.r_car_pend), 32'd0);
        check("post_reset_ped_pend", 32'(dut.r_ped_pend), 32'd0);
        idle(10);
        #1 mon_en = 1'b0;
        close_seg();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
